sync_pulse_gen: RTL and testbench

// - Consumes sync_en from the host command register file (register 0, bit 0) on the bus clock domain.
// - While enabled, drives a periodic TTL sync pulse train to the rig for host/experiment time alignment.
// - Reports running status back to the register file on its sync_in port.
// - Counts emitted pulses and externally received sync edges; both counts are exposed as 16-bit host words.

---
 rtl/sync_pulse_gen_pkg.sv | 25 ++
 rtl/sync_edge_det.sv | 32 +++
 rtl/sync_pulse_gen.sv | 146 ++++++++++++++
 tb/tb_sync_pulse_gen.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sync_pulse_gen_pkg.sv
// Shared types for the sync pulse generator: FSM encoding, readback select
// codes and the host readback request.
package sync_pulse_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_PULSE_LO = 2'd0,
    SEL_PULSE_HI = 2'd1,
    SEL_EXT_LO   = 2'd2,
    SEL_EXT_HI   = 2'd3
  } cnt_sel_e;

  typedef struct packed {
    logic     rd;
    cnt_sel_e sel;
  } rd_req_t;

  localparam int HOST_W = 16;

endpackage

// File: rtl/sync_edge_det.sv
// 2-FF synchroniser plus rising-edge detect, W independent lanes.
// A pin edge shows up on o_rise two clk edges later, for one cycle.
module sync_edge_det #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_async,
  output logic [W-1:0] o_sync,
  output logic [W-1:0] o_rise
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;
  logic [W-1:0] r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= '0;
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/sync_pulse_gen.sv
// Periodic TTL sync pulse generator with emitted-pulse and external-edge
// counters, read back by the host as coherent 16-bit word pairs.
module sync_pulse_gen
  import sync_pulse_gen_pkg::*;
#(
  parameter int PERIOD_CYC = 100000,
  parameter int HIGH_CYC   = 1000,
  parameter int CNT_W      = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sync_en,
  input  logic              i_sync_ext,
  input  logic [1:0]        i_cnt_sel,
  input  logic              i_cnt_rd,
  output logic              o_sync_out,
  output logic              o_sync_strobe,
  output logic              o_sync_busy,
  output logic [HOST_W-1:0] o_cnt_dout
);

  localparam int PH_W = $clog2(PERIOD_CYC);
  localparam logic [PH_W-1:0] HIGH_LAST   = PH_W'(HIGH_CYC - 1);
  localparam logic [PH_W-1:0] PERIOD_LAST = PH_W'(PERIOD_CYC - 1);

  if (PERIOD_CYC < 2) begin : g_bad_period
    $error("sync_pulse_gen: PERIOD_CYC must be >= 2");
  end
  if (HIGH_CYC < 1 || HIGH_CYC >= PERIOD_CYC) begin : g_bad_high
    $error("sync_pulse_gen: HIGH_CYC must satisfy 1 <= HIGH_CYC < PERIOD_CYC");
  end
  if (CNT_W < HOST_W || (CNT_W % HOST_W) != 0) begin : g_bad_cnt
    $error("sync_pulse_gen: CNT_W must be a non-zero multiple of 16");
  end

  state_e          r_state;
  state_e          w_state_nxt;
  logic [PH_W-1:0] r_phase;
  logic [PH_W-1:0] w_phase_nxt;
  logic            w_strobe;
  logic            w_ext_rise;
  logic            w_ext_sync;

  logic [CNT_W-1:0]  r_pulse_cnt;
  logic [CNT_W-1:0]  r_ext_cnt;
  logic [HOST_W-1:0] r_pulse_snap;
  logic [HOST_W-1:0] r_ext_snap;
  logic [HOST_W-1:0] r_cnt_dout;
  logic [HOST_W-1:0] w_pulse_hi;
  logic [HOST_W-1:0] w_ext_hi;
  rd_req_t           w_req;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_phase <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  // Phase runs continuously across HIGH and LOW so the period is exact;
  // sync_en is only looked at in IDLE and at the end of LOW.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase + PH_W'(1);
    case (r_state)
      ST_IDLE: begin
        w_phase_nxt = '0;
        if (i_sync_en) w_state_nxt = ST_HIGH;
      end
      ST_HIGH: begin
        if (r_phase == HIGH_LAST) w_state_nxt = ST_LOW;
      end
      ST_LOW: begin
        if (r_phase == PERIOD_LAST) begin
          w_phase_nxt = '0;
          w_state_nxt = i_sync_en ? ST_HIGH : ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_phase_nxt = '0;
      end
    endcase
  end

  always_comb begin
    o_sync_out  = (r_state == ST_HIGH);
    w_strobe    = (r_state == ST_HIGH) && (r_phase == '0);
    o_sync_busy = (r_state != ST_IDLE);
  end

  assign o_sync_strobe = w_strobe;

  sync_edge_det #(
    .W(1)
  ) u_ext_det (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_sync_ext),
    .o_sync  (w_ext_sync),
    .o_rise  (w_ext_rise)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pulse_cnt <= '0;
      r_ext_cnt   <= '0;
    end else begin
      if (w_strobe)   r_pulse_cnt <= r_pulse_cnt + CNT_W'(1);
      if (w_ext_rise) r_ext_cnt   <= r_ext_cnt + CNT_W'(1);
    end
  end

  // Only the upper word needs snapshotting: the lower word goes straight
  // to cnt_dout on the same edge, so the pair stays coherent.
  assign w_pulse_hi = HOST_W'(r_pulse_cnt >> HOST_W);
  assign w_ext_hi   = HOST_W'(r_ext_cnt >> HOST_W);
  assign w_req      = '{rd: i_cnt_rd, sel: cnt_sel_e'(i_cnt_sel)};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pulse_snap <= '0;
      r_ext_snap   <= '0;
      r_cnt_dout   <= '0;
    end else if (w_req.rd) begin
      case (w_req.sel)
        SEL_PULSE_LO: begin
          r_pulse_snap <= w_pulse_hi;
          r_cnt_dout   <= r_pulse_cnt[HOST_W-1:0];
        end
        SEL_PULSE_HI: r_cnt_dout <= r_pulse_snap;
        SEL_EXT_LO: begin
          r_ext_snap <= w_ext_hi;
          r_cnt_dout <= r_ext_cnt[HOST_W-1:0];
        end
        SEL_EXT_HI:   r_cnt_dout <= r_ext_snap;
      endcase
    end
  end

  assign o_cnt_dout = r_cnt_dout;

endmodule

// File: tb/tb_sync_pulse_gen.sv
// Randomized bench for sync_pulse_gen against a cycle-count reference model.
module tb_sync_pulse_gen;

  localparam int PERIOD = 10;
  localparam int HIGH   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sync_en = 1'b0;
  logic        sync_ext = 1'b0;
  logic [1:0]  cnt_sel = 2'd0;
  logic        cnt_rd = 1'b0;
  logic        sync_out, sync_strobe, sync_busy;
  logic [15:0] cnt_dout;

  sync_pulse_gen #(
    .PERIOD_CYC (PERIOD),
    .HIGH_CYC   (HIGH),
    .CNT_W      (32)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_sync_en     (sync_en),
    .i_sync_ext    (sync_ext),
    .i_cnt_sel     (cnt_sel),
    .i_cnt_rd      (cnt_rd),
    .o_sync_out    (sync_out),
    .o_sync_strobe (sync_strobe),
    .o_sync_busy   (sync_busy),
    .o_cnt_dout    (cnt_dout)
  );

  always #5 clk = ~clk;

  // Reference model: "running" plus cycles elapsed since the current pulse
  // started; everything observable is derived from those two numbers.
  bit          m_run = 1'b0;
  int          m_t = 0;
  logic [31:0] m_pcnt = '0;
  logic [15:0] m_psnap = '0, m_esnap = '0, m_dout = '0;
  int          m_ext_edges = 0;
  int          m_ext_base = 0;
  bit          ld_req = 1'b0;
  logic [31:0] ld_val = '0;

  always @(posedge clk) begin
    logic [31:0] e;
    if (rst) begin
      m_run = 1'b0; m_t = 0; m_pcnt = '0;
      m_psnap = '0; m_esnap = '0; m_dout = '0;
      m_ext_base = m_ext_edges;
    end else begin
      e = 32'(m_ext_edges - m_ext_base);
      if (cnt_rd) begin
        case (cnt_sel)
          2'd0: begin m_psnap = m_pcnt[31:16]; m_dout = m_pcnt[15:0]; end
          2'd1: m_dout = m_psnap;
          2'd2: begin m_esnap = e[31:16]; m_dout = e[15:0]; end
          default: m_dout = m_esnap;
        endcase
      end
      if (m_run && m_t == 0) m_pcnt = m_pcnt + 32'd1;
      if (ld_req) m_pcnt = ld_val;
      if (!m_run) begin
        if (sync_en) begin m_run = 1'b1; m_t = 0; end
      end else begin
        m_t++;
        if (m_t == PERIOD) begin
          if (sync_en) m_t = 0;
          else m_run = 1'b0;
        end
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and compare every output with the model.
  task automatic step();
    @(negedge clk);
    chk("sync_out", 32'(sync_out), 32'(m_run && m_t < HIGH));
    chk("sync_strobe", 32'(sync_strobe), 32'(m_run && m_t == 0));
    chk("sync_busy", 32'(sync_busy), 32'(m_run));
    chk("cnt_dout", 32'(cnt_dout), 32'(m_dout));
  endtask

  task automatic rd(input logic [1:0] sel);
    cnt_rd = 1'b1; cnt_sel = sel;
    step();
    cnt_rd = 1'b0;
  endtask

  initial begin
    int old;
    rst = 1'b1;
    step(); step();
    chk("reset_out", 32'(sync_out), 32'd0);
    chk("reset_dout", 32'(cnt_dout), 32'd0);
    rst = 1'b0;
    step();

    // en dropped one cycle into the pulse: full period still runs
    sync_en = 1'b1;
    step();
    chk("first_pulse", 32'(sync_out), 32'd1);
    sync_en = 1'b0;
    for (int i = 0; i < 9; i++) step();
    chk("drop_busy_end", 32'(sync_busy), 32'd1);
    step();
    chk("drop_idle", 32'(sync_busy), 32'd0);
    rd(2'd0);
    chk("drop_pcnt", 32'(cnt_dout), 32'd1);

    // reset mid-pulse, then restart with en held
    sync_en = 1'b1;
    step(); step();
    rst = 1'b1;
    step();
    chk("rst_out", 32'(sync_out), 32'd0);
    chk("rst_busy", 32'(sync_busy), 32'd0);
    rst = 1'b0;
    step();
    chk("rst_restart", 32'(sync_strobe), 32'd1);
    for (int i = 0; i < 25; i++) step();
    sync_en = 1'b0;
    for (int i = 0; i < 12; i++) step();

    // external edges: 3-cycle latency each, pulse count untouched
    rst = 1'b1; step(); rst = 1'b0; step();
    for (int k = 0; k < 5; k++) begin
      old = m_ext_edges - m_ext_base;
      #($urandom_range(1, 3));
      sync_ext = 1'b1;
      m_ext_edges++;
      step(); chk("ext_lat1", dut.r_ext_cnt, 32'(old));
      step(); chk("ext_lat2", dut.r_ext_cnt, 32'(old));
      step(); chk("ext_lat3", dut.r_ext_cnt, 32'(old + 1));
      repeat ($urandom_range(0, 2)) step();
      #($urandom_range(1, 3));
      sync_ext = 1'b0;
      repeat ($urandom_range(3, 5)) step();
    end
    rd(2'd2); chk("ext_total", 32'(cnt_dout), 32'd5);
    rd(2'd3); chk("ext_hi", 32'(cnt_dout), 32'd0);
    rd(2'd0); chk("ext_pcnt0", 32'(cnt_dout), 32'd0);

    // low-word wrap with a read coincident with the strobe
    force dut.r_pulse_cnt = 32'h0000_FFFF;
    ld_req = 1'b1; ld_val = 32'h0000_FFFF;
    step();
    release dut.r_pulse_cnt;
    ld_req = 1'b0;
    sync_en = 1'b1;
    step();
    chk("wrap_strobe", 32'(sync_strobe), 32'd1);
    rd(2'd0); chk("wrap_lo", 32'(cnt_dout), 32'h0000_FFFF);
    rd(2'd1); chk("wrap_hi", 32'(cnt_dout), 32'h0000_0000);
    rd(2'd0); chk("wrap_live_lo", 32'(cnt_dout), 32'h0000_0000);
    rd(2'd1); chk("wrap_live_hi", 32'(cnt_dout), 32'h0000_0001);

    // random enable, reset and readback traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 39) == 0) sync_en = ~sync_en;
      rst = ($urandom_range(0, 299) == 0);
      cnt_rd = ($urandom_range(0, 3) == 0);
      cnt_sel = 2'($urandom_range(0, 3));
      step();
    end
    cnt_rd = 1'b0; rst = 1'b0;
    rd(2'd0);
    rd(2'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
